// File: rtl/floatpair_split_pkg.sv
// ============================================================================
// Module : floatpair_split_pkg
// Brief  : Shared types for the float32 pair splitter and its operand FIFOs.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package floatpair_split_pkg;

    typedef logic [31:0] float32_t;

    typedef enum logic {
        SEL_A = 1'b0,
        SEL_B = 1'b1
    } pair_sel_t;

endpackage

`default_nettype wire

// File: rtl/floatpair_fifo.sv
// ============================================================================
// Module : floatpair_fifo
// Brief  : Small synchronous FIFO, registered head, no write-to-read bypass.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module floatpair_fifo
    import floatpair_split_pkg::*;
#(
    parameter int  DEPTH = 2,
    parameter type T     = float32_t
) (
    input  logic clk,
    input  logic rst,
    input  logic push,
    input  T     push_data,
    output logic full,
    input  logic pop,
    output T     head,
    output logic empty
);

    localparam int          AW           = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] c_FULL_COUNT = (AW + 1)'(DEPTH);

    generate
        if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
            $error("floatpair_fifo: DEPTH must be a power of two and >= 2");
        end
    endgenerate

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q,  count_d;
    T              mem_q [DEPTH];

    logic w_do_push;
    logic w_do_pop;

    assign full      = (count_q == c_FULL_COUNT);
    assign empty     = (count_q == '0);
    // Push is refused on full even when a pop frees a slot this same cycle.
    assign w_do_push = push & ~full;
    assign w_do_pop  = pop & ~empty;
    assign head      = empty ? T'('0) : mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (w_do_push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (w_do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({w_do_push, w_do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

endmodule

`default_nettype wire

// File: rtl/floatpair_split.sv
// ============================================================================
// Module : floatpair_split
// Brief  : Deinterleaves one float32 stream into A (even) / B (odd) operands.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module floatpair_split
    import floatpair_split_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic     clk,
    input  logic     rst,
    output logic     busy,
    input  logic     i_valid,
    input  float32_t i_data,
    output logic     i_ready,
    output logic     a_valid,
    output float32_t a_data,
    input  logic     a_ready,
    output logic     b_valid,
    output float32_t b_data,
    input  logic     b_ready
);

    pair_sel_t sel_q, sel_d;

    logic w_a_full, w_a_empty;
    logic w_b_full, w_b_empty;
    logic w_accept;

    // i_ready and busy are pure functions of registered state.
    assign i_ready  = (sel_q == SEL_A) ? ~w_a_full : ~w_b_full;
    assign w_accept = i_valid & i_ready;
    assign busy     = (sel_q == SEL_B) | ~w_a_empty | ~w_b_empty;
    assign a_valid  = ~w_a_empty;
    assign b_valid  = ~w_b_empty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sel_q <= SEL_A;
        end else begin
            sel_q <= sel_d;
        end
    end

    always_comb begin
        sel_d = sel_q;
        if (w_accept) begin
            sel_d = (sel_q == SEL_A) ? SEL_B : SEL_A;
        end
    end

    floatpair_fifo #(
        .DEPTH (DEPTH),
        .T     (float32_t)
    ) u_fifo_a (
        .clk       (clk),
        .rst       (rst),
        .push      (w_accept & (sel_q == SEL_A)),
        .push_data (i_data),
        .full      (w_a_full),
        .pop       (a_ready),
        .head      (a_data),
        .empty     (w_a_empty)
    );

    floatpair_fifo #(
        .DEPTH (DEPTH),
        .T     (float32_t)
    ) u_fifo_b (
        .clk       (clk),
        .rst       (rst),
        .push      (w_accept & (sel_q == SEL_B)),
        .push_data (i_data),
        .full      (w_b_full),
        .pop       (b_ready),
        .head      (b_data),
        .empty     (w_b_empty)
    );

endmodule

`default_nettype wire

// File: tb/tb_floatpair_split.sv
// ============================================================================
// Module : tb_floatpair_split
// Brief  : Directed, table-driven self-checking bench for floatpair_split.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_floatpair_split;

    logic        clk;
    logic        rst;
    logic        busy;
    logic        i_valid;
    logic [31:0] i_data;
    logic        i_ready;
    logic        a_valid;
    logic [31:0] a_data;
    logic        a_ready;
    logic        b_valid;
    logic [31:0] b_data;
    logic        b_ready;

    int n_checks;
    int n_errors;

    floatpair_split #(.DEPTH(2)) u_dut (
        .clk     (clk),
        .rst     (rst),
        .busy    (busy),
        .i_valid (i_valid),
        .i_data  (i_data),
        .i_ready (i_ready),
        .a_valid (a_valid),
        .a_data  (a_data),
        .a_ready (a_ready),
        .b_valid (b_valid),
        .b_data  (b_data),
        .b_ready (b_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst_before;
        logic        iv;
        logic [31:0] id;
        logic        ar;
        logic        br;
        logic        exp_ir;
        logic        exp_av;
        logic [31:0] exp_ad;
        logic        exp_bv;
        logic [31:0] exp_bd;
        logic        exp_busy;
    } vec_t;

    localparam int NVEC = 15;
    vec_t vecs [NVEC];

    function automatic vec_t mk(input logic rb, input logic iv, input logic [31:0] id,
                                input logic ar, input logic br, input logic eir,
                                input logic eav, input logic [31:0] ead,
                                input logic ebv, input logic [31:0] ebd, input logic ebusy);
        vec_t v;
        v.rst_before = rb;  v.iv = iv;  v.id = id;  v.ar = ar;  v.br = br;
        v.exp_ir = eir;  v.exp_av = eav;  v.exp_ad = ead;
        v.exp_bv = ebv;  v.exp_bd = ebd;  v.exp_busy = ebusy;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_outs(input string tag, input logic eir, input logic eav,
                            input logic [31:0] ead, input logic ebv,
                            input logic [31:0] ebd, input logic ebusy);
        chk({tag, ".i_ready"}, {31'd0, i_ready}, {31'd0, eir});
        chk({tag, ".a_valid"}, {31'd0, a_valid}, {31'd0, eav});
        chk({tag, ".a_data"},  a_data, ead);
        chk({tag, ".b_valid"}, {31'd0, b_valid}, {31'd0, ebv});
        chk({tag, ".b_data"},  b_data, ebd);
        chk({tag, ".busy"},    {31'd0, busy}, {31'd0, ebusy});
    endtask

    // Inputs change at posedge+1; everything else is aligned to that point.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    localparam logic [31:0] W0 = 32'h1111_0000, W1 = 32'h2222_0001, W2 = 32'h3333_0002;
    localparam logic [31:0] W3 = 32'h4444_0003, W4 = 32'h5555_0004, W5 = 32'h8000_0005;

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst = 1'b0;  i_valid = 1'b0;  i_data = '0;  a_ready = 1'b0;  b_ready = 1'b0;

        // Asynchronous reset with no clock edge in between.
        #2 rst = 1'b1;
        #1 chk_outs("async_rst", 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        @(posedge clk);
        #1 rst = 1'b0;

        // Simple pair, then A back-pressure with 6 words.
        vecs[0]  = mk(1'b0, 1'b1, 32'h3F80_0000, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0,         1'b0, 32'h0,         1'b0);
        vecs[1]  = mk(1'b0, 1'b1, 32'h4000_0000, 1'b1, 1'b1, 1'b1, 1'b1, 32'h3F80_0000, 1'b0, 32'h0,         1'b1);
        vecs[2]  = mk(1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 1'b1, 1'b0, 32'h0,         1'b1, 32'h4000_0000, 1'b1);
        vecs[3]  = mk(1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 1'b1, 1'b0, 32'h0,         1'b0, 32'h0,         1'b0);
        vecs[4]  = mk(1'b1, 1'b1, W0,            1'b0, 1'b1, 1'b1, 1'b0, 32'h0,         1'b0, 32'h0,         1'b0);
        vecs[5]  = mk(1'b0, 1'b1, W1,            1'b0, 1'b1, 1'b1, 1'b1, W0,            1'b0, 32'h0,         1'b1);
        vecs[6]  = mk(1'b0, 1'b1, W2,            1'b0, 1'b1, 1'b1, 1'b1, W0,            1'b1, W1,            1'b1);
        vecs[7]  = mk(1'b0, 1'b1, W3,            1'b0, 1'b1, 1'b1, 1'b1, W0,            1'b0, 32'h0,         1'b1);
        vecs[8]  = mk(1'b0, 1'b1, W4,            1'b0, 1'b1, 1'b0, 1'b1, W0,            1'b1, W3,            1'b1);
        // A full and popped this cycle: input still refused.
        vecs[9]  = mk(1'b0, 1'b1, W4,            1'b1, 1'b1, 1'b0, 1'b1, W0,            1'b0, 32'h0,         1'b1);
        vecs[10] = mk(1'b0, 1'b1, W4,            1'b1, 1'b1, 1'b1, 1'b1, W2,            1'b0, 32'h0,         1'b1);
        vecs[11] = mk(1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 1'b1, 1'b1, W4,            1'b0, 32'h0,         1'b1);
        vecs[12] = mk(1'b0, 1'b1, W5,            1'b1, 1'b1, 1'b1, 1'b0, 32'h0,         1'b0, 32'h0,         1'b1);
        vecs[13] = mk(1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 1'b1, 1'b0, 32'h0,         1'b1, W5,            1'b1);
        vecs[14] = mk(1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 1'b1, 1'b0, 32'h0,         1'b0, 32'h0,         1'b0);

        for (int i = 0; i < NVEC; i++) begin
            if (vecs[i].rst_before) begin
                i_valid = 1'b0;
                do_reset();
            end
            i_valid = vecs[i].iv;
            i_data  = vecs[i].id;
            a_ready = vecs[i].ar;
            b_ready = vecs[i].br;
            @(negedge clk);
            chk_outs($sformatf("vec%0d", i), vecs[i].exp_ir, vecs[i].exp_av, vecs[i].exp_ad,
                     vecs[i].exp_bv, vecs[i].exp_bd, vecs[i].exp_busy);
            step();
        end

        // Reset with three words buffered and B selected.
        i_valid = 1'b0;
        do_reset();
        a_ready = 1'b0;  b_ready = 1'b0;
        i_valid = 1'b1;
        i_data = W0;  step();
        i_data = W1;  step();
        i_data = W2;  step();
        i_valid = 1'b0;
        chk_outs("pre_rst", 1'b1, 1'b1, W0, 1'b1, W1, 1'b1);
        #2 rst = 1'b1;
        #1 chk_outs("mid_rst", 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        @(posedge clk);
        #1 rst = 1'b0;
        i_valid = 1'b1;  i_data = 32'h3F80_0000;
        step();
        i_valid = 1'b0;
        chk_outs("post_rst", 1'b1, 1'b1, 32'h3F80_0000, 1'b0, 32'h0, 1'b1);

        // Lone NaN word: A drains, busy persists because B is selected.
        do_reset();
        a_ready = 1'b1;  b_ready = 1'b1;
        i_valid = 1'b1;  i_data = 32'h7FC0_0001;
        step();
        i_valid = 1'b0;
        chk_outs("nan_a", 1'b1, 1'b1, 32'h7FC0_0001, 1'b0, 32'h0, 1'b1);
        for (int k = 0; k < 5; k++) begin
            step();
            chk_outs($sformatf("nan_hold%0d", k), 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
